// File: rtl/cache_nway_wb_if.sv
// Core-side and physical-memory-side buses of cache_nway_wb.
// The cache uses the slave view; the core/memory environment uses the master view.
interface cache_nway_wb_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_byte_enable;
    logic [15:0]       mem_rdata;
    logic              mem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with tree pseudo-LRU replacement.
// Optional feature macro CACHE_PERF_CNT_EN adds saturating hit/miss/write-back counters.
module cache_nway_wb #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic clk,
    input  logic reset,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count,
`endif
    cache_nway_wb_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WORD_W = OFF_W - 1;
    localparam int WAY_W  = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t state;
    state_t state_next;

    logic [WAYS-1:0]   valid [SETS];
    logic [WAYS-1:0]   dirty [SETS];
    logic [TAG_W-1:0]  tags  [SETS][WAYS];
    logic [LINE_W-1:0] lines [SETS][WAYS];
    logic [WAYS-2:0]   plru  [SETS];
    logic [WAY_W-1:0]  victim;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic [OFF_W+2:0]  bit_base;
    logic              is_write;
    logic              addr_unused;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              has_free;
    logic [WAY_W-1:0]  free_way;
    logic [WAY_W-1:0]  miss_way;
    logic [LINE_W-1:0] hit_line;
    logic [15:0]       hit_word;
    logic [15:0]       merged_word;

    // Tree bits are stored heap-style: node n lives at bit n-1, children are 2n and 2n+1.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            node = 2 * node + (bits[node-1] ? 1 : 0);
        end
        return WAY_W'(node - WAYS);
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] result;
        int              node;
        logic            dir;
        result = bits;
        node   = 1;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            dir            = way[l];
            result[node-1] = ~dir;
            node           = 2 * node + (dir ? 1 : 0);
        end
        return result;
    endfunction

    assign req_tag     = bus.mem_address[ADDR_W-1:IDX_W+OFF_W];
    assign idx         = bus.mem_address[IDX_W+OFF_W-1:OFF_W];
    assign word        = bus.mem_address[OFF_W-1:1];
    assign bit_base    = {word, 4'b0000};
    assign is_write    = bus.mem_write;
    assign addr_unused = bus.mem_address[0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tags[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Empty ways are always filled before PLRU is consulted, lowest index first.
    always_comb begin
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[idx][w]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign miss_way    = has_free ? free_way : plru_victim(plru[idx]);
    assign hit_line    = lines[idx][hit_way];
    assign hit_word    = hit_line[bit_base +: 16];
    assign merged_word = {bus.mem_byte_enable[1] ? bus.mem_wdata[15:8] : hit_word[15:8],
                          bus.mem_byte_enable[0] ? bus.mem_wdata[7:0]  : hit_word[7:0]};

    assign bus.mem_rdata    = hit_word;
    assign bus.pmem_wdata   = lines[idx][victim];
    assign bus.pmem_address = {(state == WRITEBACK) ? tags[idx][victim] : req_tag,
                               idx, {OFF_W{1'b0}}};

    always_comb begin
        state_next     = state;
        bus.mem_resp   = 1'b0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    bus.mem_resp = 1'b1;
                    state_next   = IDLE;
                end else if (valid[idx][miss_way] && dirty[idx][miss_way]) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                if (bus.pmem_resp) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) state_next = COMPARE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Tags and line data are cleared too so the unqualified outputs never carry X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tags[s][w]  <= '0;
                    lines[s][w] <= '0;
                end
            end
            victim <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (hit) begin
                        plru[idx] <= plru_touch(plru[idx], hit_way);
                        if (is_write) begin
                            lines[idx][hit_way][bit_base +: 16] <= merged_word;
                            dirty[idx][hit_way]                 <= 1'b1;
                        end
                    end else begin
                        victim <= miss_way;
                    end
                end
                ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        lines[idx][victim] <= bus.pmem_rdata;
                        tags[idx][victim]  <= req_tag;
                        valid[idx][victim] <= 1'b1;
                        dirty[idx][victim] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // The hit that follows a refill is not a first-pass hit, so it is excluded from hit_count.
    logic refilled;

    always_ff @(posedge clk) begin
        if (reset) begin
            refilled   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == ALLOCATE && bus.pmem_resp) refilled <= 1'b1;
            else if (state == IDLE)                 refilled <= 1'b0;
            if (state == COMPARE && hit && !refilled && hit_count != '1)
                hit_count <= hit_count + 32'd1;
            if (state == COMPARE && !hit && miss_count != '1)
                miss_count <= miss_count + 32'd1;
            if (state == COMPARE && state_next == WRITEBACK && wb_count != '1)
                wb_count <= wb_count + 32'd1;
        end
    end
`else
    // Counters are absent in this build.
`endif

    req_held_a: assert property (@(posedge clk) disable iff (reset)
        (state != IDLE) |-> (bus.mem_read || bus.mem_write));
endmodule

// File: tb/tb_cache_nway_wb.sv
// Randomized scoreboard bench for cache_nway_wb (4-way build) against a flat-memory
// and tag/PLRU reference model; expected bus events are queued and checked by a monitor.
module tb_cache_nway_wb;
    localparam int WAYS       = 4;
    localparam int SETS       = 8;
    localparam int LINE_BYTES = 16;
    localparam int ADDR_W     = 16;
    localparam int LINE_W     = 8 * LINE_BYTES;

    localparam int K_RESP = 0;
    localparam int K_WB   = 1;
    localparam int K_FILL = 2;

    typedef struct {
        int                kind;
        logic [15:0]       addr;
        logic [LINE_W-1:0] line;
        logic [15:0]       data;
        bit                check_data;
        bit                is_hit;
        int unsigned       issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mem_hold = 1'b0;
    int          inject_req = 0;
    int          inject_ack = 0;

    logic [7:0] pmem [65536];
    logic [7:0] gold [65536];

    bit m_valid [SETS][WAYS];
    bit m_dirty [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    bit m_tree  [SETS][WAYS];
    int hit_cnt  = 0;
    int miss_cnt = 0;
    int wb_cnt   = 0;

    exp_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_nway_wb_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] wb_count;
`endif

    cache_nway_wb #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef CACHE_PERF_CNT_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count),
`endif
        .bus        (bus)
    );

    function automatic logic [LINE_W-1:0] gold_line(input int base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_BYTES; k++) l[8*k +: 8] = gold[base + k];
        return l;
    endfunction

    // Walk the halving ranges: bit 0 sends the victim to the lower half of the range.
    function automatic int model_victim(input int s);
        int lo, size, node;
        lo = 0; size = WAYS; node = 1;
        while (size > 1) begin
            size = size / 2;
            if (m_tree[s][node]) begin
                lo   = lo + size;
                node = 2 * node + 1;
            end else begin
                node = 2 * node;
            end
        end
        return lo;
    endfunction

    function automatic void model_touch(input int s, input int way);
        int lo, size, node;
        lo = 0; size = WAYS; node = 1;
        while (size > 1) begin
            size = size / 2;
            if (way >= lo + size) begin
                m_tree[s][node] = 1'b0;
                lo   = lo + size;
                node = 2 * node + 1;
            end else begin
                m_tree[s][node] = 1'b1;
                node = 2 * node;
            end
        end
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = 0;
                m_tree[s][w]  = 1'b0;
            end
    endfunction

    task automatic compare(input string name, input logic [LINE_W-1:0] actual,
                           input logic [LINE_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic check_output(input int kind);
        exp_t e;
        int   lat;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d expected none", kind);
            return;
        end
        e = expq.pop_front();
        if (e.kind != kind) begin
            checks++;
            errors++;
            $display("[TB] FAIL event_order: got kind %0d expected kind %0d", kind, e.kind);
            return;
        end
        case (kind)
            K_WB: begin
                compare("wb_address", LINE_W'(bus.pmem_address), LINE_W'(e.addr));
                compare("wb_line", bus.pmem_wdata, e.line);
            end
            K_FILL: compare("fill_address", LINE_W'(bus.pmem_address), LINE_W'(e.addr));
            default: begin
                if (e.check_data) compare("read_data", LINE_W'(bus.mem_rdata), LINE_W'(e.data));
                lat = int'(cyc - e.issue) + 1;
                checks++;
                if (e.is_hit ? (lat != 2) : (lat <= 2)) begin
                    errors++;
                    $display("[TB] FAIL latency: got %0d cycles expected %s", lat,
                             e.is_hit ? "2" : "more than 2");
                end
            end
        endcase
    endtask

    // Predict the response from the reference model, then drive and hold the request until mem_resp.
    task automatic apply_stimulus(input logic [15:0] addr, input bit rd, input bit wr,
                                  input logic [15:0] wdata, input logic [1:0] be);
        int   s, tg, way, a, n;
        bit   hit;
        exp_t e;
        @(negedge clk);
        s   = int'(addr[6:4]);
        tg  = int'(addr[15:7]);
        a   = int'({addr[15:1], 1'b0});
        hit = 1'b0;
        way = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == tg) begin
                hit = 1'b1;
                way = w;
            end
        if (!hit) begin
            miss_cnt++;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
            if (way < 0) way = model_victim(s);
            if (m_valid[s][way] && m_dirty[s][way]) begin
                wb_cnt++;
                e = '{K_WB, 16'((m_tag[s][way] << 7) | (s << 4)), gold_line((m_tag[s][way] << 7) | (s << 4)),
                      16'h0, 1'b0, 1'b0, 0};
                expq.push_back(e);
            end
            e = '{K_FILL, 16'((tg << 7) | (s << 4)), '0, 16'h0, 1'b0, 1'b0, 0};
            expq.push_back(e);
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
            m_tag[s][way]   = tg;
        end else begin
            hit_cnt++;
        end
        e = '{K_RESP, addr, '0, {gold[a + 1], gold[a]}, !wr, hit, cyc};
        expq.push_back(e);
        model_touch(s, way);
        if (wr) begin
            m_dirty[s][way] = 1'b1;
            if (be[0]) gold[a]     = wdata[7:0];
            if (be[1]) gold[a + 1] = wdata[15:8];
        end
        bus.mem_address     = addr;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_wdata       = wdata;
        bus.mem_byte_enable = be;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_resp && n < 300);
        if (!bus.mem_resp) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_timeout: got no mem_resp for address %0h expected one within 300 cycles", addr);
            finish_run();
        end
        @(negedge clk);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin : responder
        int                base;
        logic [LINE_W-1:0] l;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (inject_req != inject_ack) begin
                bus.pmem_rdata = {4{$urandom}};
                bus.pmem_resp  = 1'b1;
                @(negedge clk);
                bus.pmem_resp  = 1'b0;
                inject_ack     = inject_req;
            end else if (!mem_hold && !reset && (bus.pmem_read || bus.pmem_write)) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                base = int'(bus.pmem_address);
                if (bus.pmem_write) begin
                    for (int k = 0; k < LINE_BYTES; k++) pmem[base + k] = bus.pmem_wdata[8*k +: 8];
                end else begin
                    for (int k = 0; k < LINE_BYTES; k++) l[8*k +: 8] = pmem[base + k];
                    bus.pmem_rdata = l;
                end
                bus.pmem_resp = 1'b1;
                @(negedge clk);
                bus.pmem_resp = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit prev_pr, prev_pw;
        prev_pr = 1'b0;
        prev_pw = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pr = 1'b0;
                prev_pw = 1'b0;
            end else begin
                if (bus.pmem_write && !prev_pw) check_output(K_WB);
                if (bus.pmem_read && !prev_pr)  check_output(K_FILL);
                if (bus.mem_resp)               check_output(K_RESP);
                prev_pw = bus.pmem_write;
                prev_pr = bus.pmem_read;
            end
        end
    end

    initial begin : stimulus
        exp_t        e;
        int          n;
        logic [15:0] addr;
        int          op;
        reset               = 1'b1;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = '0;
        bus.mem_wdata       = '0;
        bus.mem_byte_enable = '0;
        for (int i = 0; i < 65536; i++) begin
            pmem[i] = 8'($urandom);
            gold[i] = pmem[i];
        end
        pmem[16'h0042] = 8'hEF; pmem[16'h0043] = 8'hBE;
        gold[16'h0042] = 8'hEF; gold[16'h0043] = 8'hBE;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        compare("reset_mem_resp", LINE_W'(bus.mem_resp), '0);
        compare("reset_pmem_read", LINE_W'(bus.pmem_read), '0);
        compare("reset_pmem_write", LINE_W'(bus.pmem_write), '0);

        // Reset in the middle of a fill: the transfer is dropped and a late pmem_resp is ignored.
        mem_hold = 1'b1;
        @(negedge clk);
        e = '{K_FILL, 16'h0040, '0, 16'h0, 1'b0, 1'b0, 0};
        expq.push_back(e);
        bus.mem_address = 16'h0042;
        bus.mem_read    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pmem_read && n < 50);
        if (!bus.pmem_read) begin
            checks++;
            errors++;
            $display("[TB] FAIL fill_timeout: got no pmem_read expected one within 50 cycles");
            finish_run();
        end
        reset = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.mem_read = 1'b0;
        compare("abort_pmem_read", LINE_W'(bus.pmem_read), '0);
        compare("abort_mem_resp", LINE_W'(bus.mem_resp), '0);
        @(negedge clk);
        inject_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compare("late_resp_mem_resp", LINE_W'(bus.mem_resp), '0);
            compare("late_resp_pmem_read", LINE_W'(bus.pmem_read), '0);
        end
        mem_hold = 1'b0;

        apply_stimulus(16'h0042, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h0042, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h0042, 1'b0, 1'b1, 16'h1234, 2'b10);
        apply_stimulus(16'h0042, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h0842, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h1042, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h1842, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h0042, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h1042, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h2042, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h2842, 1'b1, 1'b0, 16'h0000, 2'b00);
        apply_stimulus(16'h3042, 1'b1, 1'b0, 16'h0000, 2'b00);

        for (int i = 0; i < 400; i++) begin
            addr = 16'(($urandom_range(0, 5) << 7) | ($urandom_range(0, 3) << 4) |
                       ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
            op = int'($urandom_range(0, 9));
            apply_stimulus(addr, op <= 5 || op == 9, op >= 6, 16'($urandom), 2'($urandom));
        end

        repeat (3) @(negedge clk);
        compare("pending_expectations", LINE_W'(expq.size()), '0);
`ifdef CACHE_PERF_CNT_EN
        compare("hit_count", LINE_W'(hit_count), LINE_W'(hit_cnt));
        compare("miss_count", LINE_W'(miss_count), LINE_W'(miss_cnt));
        compare("wb_count", LINE_W'(wb_count), LINE_W'(wb_cnt));
`endif
        $display("[TB] model saw %0d hits, %0d misses, %0d write-backs", hit_cnt, miss_cnt, wb_cnt);
        finish_run();
    end
endmodule
